// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer: DEPTH-entry write-back FIFO ahead of the register file, with a
// registered one-hot retire stage and newest-first forwarding of pending writes.
module regfile_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                wr_valid,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  output logic                wr_ready,
  input  logic                hold,
  output logic [(1<<AW)-1:0]  rf_we,
  output logic [DW-1:0]       rf_wdata,
  input  logic [AW-1:0]       fwd_addr,
  output logic                fwd_hit,
  output logic [DW-1:0]       fwd_data,
  output logic [AW-1:0]       count,
  output logic                empty
);

  localparam int NR = 1 << AW;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] r_mem_addr [DEPTH];
  logic [DW-1:0] r_mem_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [NR-1:0] r_rf_we;
  logic [DW-1:0] r_rf_wdata;

  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_head_addr;
  logic [NR-1:0] w_head_onehot;
  logic          w_fwd_hit;
  logic [DW-1:0] w_fwd_data;

  // Full blocks new writes even when a pop happens on the same edge.
  assign wr_ready    = (r_count != FULL);
  assign w_push      = wr_valid && wr_ready;
  assign w_pop       = !hold && (r_count != '0);
  assign w_head_addr = r_mem_addr[r_head];

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    w_head_onehot = '0;
    if (w_head_addr != '0) w_head_onehot[w_head_addr] = 1'b1;
  end

  // NOTE: the entry storage has no reset; r_count alone says which slots are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_tail] <= wr_addr;
      r_mem_data[r_tail] <= wr_data;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rf_we    <= '0;
      r_rf_wdata <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop) begin
        r_head     <= r_head + PW'(1);
        r_rf_we    <= w_head_onehot;
        r_rf_wdata <= r_mem_data[r_head];
      end else begin
        r_rf_we    <= '0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage is oldest; walking the FIFO head->tail lets the newest match win.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    if (r_rf_we[fwd_addr]) begin
      w_fwd_hit  = 1'b1;
      w_fwd_data = r_rf_wdata;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_mem_addr[r_head + PW'(i)] == fwd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_mem_data[r_head + PW'(i)];
      end
    end
    if (fwd_addr == '0) begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = '0;
    end
  end

  assign fwd_hit  = w_fwd_hit;
  assign fwd_data = w_fwd_data;
  assign rf_we    = r_rf_we;
  assign rf_wdata = r_rf_wdata;
  assign count    = AW'(r_count);
  assign empty    = (r_count == '0) && (r_rf_we == '0);

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed bench for regfile_write_buffer: reset, latency, full/stall, register 0,
// forwarding priority, sustained enqueue+retire and mid-stream reset.
module tb_regfile_write_buffer;

  logic        clk;
  logic        clr_n;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        hold;
  logic [31:0] rf_we;
  logic [31:0] rf_wdata;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [4:0]  count;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_buffer #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .hold     (hold),
    .rf_we    (rf_we),
    .rf_wdata (rf_wdata),
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .count    (count),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; hold = 1'b0; fwd_addr = 5'd3;
    #1;
    n_checks++; if (rf_we !== 32'h0) begin n_fail++; $display("FAIL reset_rf_we: got %h expected %h", rf_we, 32'h0); end
    n_checks++; if (rf_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_rf_wdata: got %h expected %h", rf_wdata, 32'h0); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected %0d", count, 0); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected %b", wr_ready, 1'b1); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected %b", empty, 1'b1); end
    n_checks++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_hit: got %b expected %b", fwd_hit, 1'b0); end
    step();
    step();
    clr_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    hold = 1'b0; wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; fwd_addr = 5'd5;
    step();  // edge 1: accepted
    wr_valid = 1'b0;
    #1;
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL single_count1: got %0d expected %0d", count, 1); end
    n_checks++; if (rf_we !== 32'h0) begin n_fail++; $display("FAIL single_we_e1: got %h expected %h", rf_we, 32'h0); end
    n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_fwd_fifo: got %b/%h expected 1/%h", fwd_hit, fwd_data, 32'hDEADBEEF); end
    step();  // edge 2: retired into output stage
    n_checks++; if (rf_we !== 32'h20) begin n_fail++; $display("FAIL single_we_e2: got %h expected %h", rf_we, 32'h20); end
    n_checks++; if (rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wdata: got %h expected %h", rf_wdata, 32'hDEADBEEF); end
    n_checks++; if (count !== 5'd0 || empty !== 1'b0) begin n_fail++; $display("FAIL single_count_empty_e2: got %0d/%b expected 0/0", count, empty); end
    n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_fwd_out: got %b/%h expected 1/%h", fwd_hit, fwd_data, 32'hDEADBEEF); end
    step();  // edge 3: idle
    n_checks++; if (rf_we !== 32'h0) begin n_fail++; $display("FAIL single_we_e3: got %h expected %h", rf_we, 32'h0); end
    n_checks++; if (rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wdata_hold: got %h expected %h", rf_wdata, 32'hDEADBEEF); end
    n_checks++; if (empty !== 1'b1 || fwd_hit !== 1'b0) begin n_fail++; $display("FAIL single_idle: got empty=%b hit=%b expected 1/0", empty, fwd_hit); end
  endtask

  task automatic test_full();
    logic [31:0] exp_we   [5];
    logic [31:0] exp_data [5];
    logic [4:0]  exp_cnt  [5];
    exp_we   = '{32'h2, 32'h4, 32'h8, 32'h10, 32'h200};
    exp_data = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'h99};
    exp_cnt  = '{5'd3, 5'd3, 5'd2, 5'd1, 5'd0};
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wr_valid = 1'b1; wr_addr = 5'(i); wr_data = 32'hA0 + 32'(i);
      step();
    end
    wr_addr = 5'd9; wr_data = 32'h99;  // 5th request, stays asserted
    #1;
    n_checks++; if (count !== 5'd4) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", count, 4); end
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected %b", wr_ready, 1'b0); end
    step();
    n_checks++; if (count !== 5'd4 || rf_we !== 32'h0) begin n_fail++; $display("FAIL full_stall: got count=%0d we=%h expected 4/0", count, rf_we); end
    hold = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 1) wr_valid = 1'b0;
      n_checks++; if (rf_we !== exp_we[k] || rf_wdata !== exp_data[k]) begin n_fail++; $display("FAIL full_retire%0d: got %h/%h expected %h/%h", k, rf_we, rf_wdata, exp_we[k], exp_data[k]); end
      n_checks++; if (count !== exp_cnt[k]) begin n_fail++; $display("FAIL full_count%0d: got %0d expected %0d", k, count, exp_cnt[k]); end
      if (k == 0) begin
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop: got %b expected %b", wr_ready, 1'b1); end
      end
    end
    step();
    n_checks++; if (rf_we !== 32'h0 || empty !== 1'b1) begin n_fail++; $display("FAIL full_drained: got we=%h empty=%b expected 0/1", rf_we, empty); end
  endtask

  task automatic test_reg0();
    hold = 1'b0; wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; fwd_addr = 5'd0;
    step();
    wr_valid = 1'b0;
    #1;
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL reg0_count1: got %0d expected %0d", count, 1); end
    n_checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin n_fail++; $display("FAIL reg0_fwd: got %b/%h expected 0/0", fwd_hit, fwd_data); end
    step();
    n_checks++; if (count !== 5'd0 || rf_we !== 32'h0) begin n_fail++; $display("FAIL reg0_retire: got count=%0d we=%h expected 0/0", count, rf_we); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reg0_empty: got %b expected %b", empty, 1'b1); end
  endtask

  task automatic test_fwd_priority();
    hold = 1'b1; fwd_addr = 5'd7;
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h11; step();
    wr_addr = 5'd7; wr_data = 32'h22; step();
    wr_addr = 5'd8; wr_data = 32'h33;  // not yet accepted
    #1;
    n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin n_fail++; $display("FAIL fwd_newest: got %b/%h expected 1/%h", fwd_hit, fwd_data, 32'h22); end
    fwd_addr = 5'd8;
    #1;
    n_checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin n_fail++; $display("FAIL fwd_incoming_unseen: got %b/%h expected 0/0", fwd_hit, fwd_data); end
    wr_valid = 1'b0; fwd_addr = 5'd7; hold = 1'b0;
    step();
    n_checks++; if (rf_we !== 32'h80 || rf_wdata !== 32'h11) begin n_fail++; $display("FAIL fwd_out_stage: got %h/%h expected %h/%h", rf_we, rf_wdata, 32'h80, 32'h11); end
    n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin n_fail++; $display("FAIL fwd_fifo_over_out: got %b/%h expected 1/%h", fwd_hit, fwd_data, 32'h22); end
    step();
    n_checks++; if (rf_wdata !== 32'h22 || fwd_data !== 32'h22 || count !== 5'd0) begin n_fail++; $display("FAIL fwd_second: got wdata=%h fwd=%h count=%0d expected 22/22/0", rf_wdata, fwd_data, count); end
    step();
    n_checks++; if (fwd_hit !== 1'b0 || rf_we !== 32'h0) begin n_fail++; $display("FAIL fwd_cleared: got hit=%b we=%h expected 0/0", fwd_hit, rf_we); end
  endtask

  task automatic test_simultaneous();
    logic [4:0]  q_addr [$];
    logic [31:0] q_data [$];
    logic [4:0]  a;
    logic [31:0] d;
    hold = 1'b1; wr_valid = 1'b1;
    wr_addr = 5'd10; wr_data = 32'hA10; q_addr.push_back(wr_addr); q_data.push_back(wr_data); step();
    wr_addr = 5'd11; wr_data = 32'hA11; q_addr.push_back(wr_addr); q_data.push_back(wr_data); step();
    hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_addr = 5'(12 + i); wr_data = 32'hB00 + 32'(i);
      q_addr.push_back(wr_addr); q_data.push_back(wr_data);
      step();
      a = q_addr.pop_front(); d = q_data.pop_front();
      n_checks++; if (rf_we !== (32'h1 << a) || rf_wdata !== d) begin n_fail++; $display("FAIL simul_order%0d: got %h/%h expected %h/%h", i, rf_we, rf_wdata, 32'h1 << a, d); end
      n_checks++; if (count !== 5'd2) begin n_fail++; $display("FAIL simul_count%0d: got %0d expected %0d", i, count, 2); end
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      a = q_addr.pop_front(); d = q_data.pop_front();
      n_checks++; if (rf_we !== (32'h1 << a) || rf_wdata !== d) begin n_fail++; $display("FAIL simul_drain%0d: got %h/%h expected %h/%h", i, rf_we, rf_wdata, 32'h1 << a, d); end
    end
    step();
    n_checks++; if (empty !== 1'b1 || count !== 5'd0) begin n_fail++; $display("FAIL simul_empty: got empty=%b count=%0d expected 1/0", empty, count); end
  endtask

  task automatic test_reset_mid();
    hold = 1'b1; wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 5'(3 + i); wr_data = 32'hC3 + 32'(i);
      step();
    end
    wr_valid = 1'b0; hold = 1'b0;
    step();
    n_checks++; if (rf_we !== 32'h8 || count !== 5'd3) begin n_fail++; $display("FAIL rstmid_pre: got we=%h count=%0d expected 8/3", rf_we, count); end
    #2 clr_n = 1'b0;
    fwd_addr = 5'd5;
    #1;
    n_checks++; if (rf_we !== 32'h0 || count !== 5'd0) begin n_fail++; $display("FAIL rstmid_async: got we=%h count=%0d expected 0/0", rf_we, count); end
    n_checks++; if (wr_ready !== 1'b1 || empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_flags: got ready=%b empty=%b expected 1/1", wr_ready, empty); end
    n_checks++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL rstmid_fwd: got %b expected %b", fwd_hit, 1'b0); end
    step();
    clr_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (rf_we !== 32'h0 || count !== 5'd0) begin n_fail++; $display("FAIL rstmid_no_retire%0d: got we=%h count=%0d expected 0/0", i, rf_we, count); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_reg0();
    test_fwd_priority();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
